// File: rtl/imem_loader.sv
// imem_loader: receives a program as a byte stream and writes it into IMEM.
// Stream = 16-bit big-endian word count N, then N big-endian 32-bit words,
// written to consecutive word addresses starting at 0. cpu_hold keeps the
// core stalled while a load is running.
//
// Byte handshake: a byte moves on a rising edge exactly when in_valid and
// in_ready are both high; in_ready depends only on the state register, so it
// never depends on in_valid within the same cycle.
module imem_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_HDR_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;

  // Timeout counter only needs to reach TIMEOUT-2 before it fires.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [2:0]        r_state;
  logic [7:0]        r_n_hi;
  logic [15:0]       r_n;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_asm;
  logic [ADDR_W:0]   r_words;
  logic [TW-1:0]     r_tcnt;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_ready;
  logic              w_accept;
  logic [15:0]       w_n;
  logic              w_n_bad;
  logic [ADDR_W:0]   w_words_nx;
  logic              w_last;
  logic              w_tmo;

  assign w_ready    = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) ||
                      (r_state == S_DATA);
  assign w_accept   = in_valid && w_ready;
  assign w_n        = {r_n_hi, in_data};
  // A count of zero or one that overflows the memory aborts the load.
  assign w_n_bad    = (w_n == 16'd0) || (32'(w_n) > (32'd1 << ADDR_W));
  assign w_words_nx = r_words + (ADDR_W+1)'(1);
  assign w_last     = (32'(w_words_nx) == 32'(r_n));
  // Fires on the idle cycle that would bring the counter to TIMEOUT-1.
  assign w_tmo      = !w_accept && (r_tcnt == TW'(TIMEOUT - 2));

  assign in_ready     = w_ready;
  assign mem_we       = (r_state == S_WRITE);
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign busy         = (r_state != S_IDLE);
  assign cpu_hold     = busy;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words;
  assign dbg_state    = r_state;

  // Load FSM: header capture, byte counting, word count, timeout and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_n_hi     <= '0;
      r_n        <= '0;
      r_byte_idx <= '0;
      r_words    <= '0;
      r_tcnt     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_HDR_HI;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_words <= '0;
            r_tcnt  <= '0;
          end
        end
        S_HDR_HI, S_HDR_LO, S_DATA: begin
          if (w_accept) begin
            r_tcnt <= '0;
            if (r_state == S_HDR_HI) begin
              r_n_hi  <= in_data;
              r_state <= S_HDR_LO;
            end else if (r_state == S_HDR_LO) begin
              r_n <= w_n;
              if (w_n_bad) begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_byte_idx <= '0;
                r_state    <= S_DATA;
              end
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
              if (r_byte_idx == 2'd3) r_state <= S_WRITE;
            end
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_WRITE: begin
          r_words <= w_words_nx;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DATA;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word assembly; address and data are latched as the 4th byte arrives and
  // then hold until the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept && (r_state == S_DATA)) begin
      r_asm <= {r_asm[15:0], in_data};
      if (r_byte_idx == 2'd3) begin
        r_wdata <= {r_asm, in_data};
        r_addr  <= r_words[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams are built per test, a stream
// model derives the expected IMEM writes and final status, and one compare
// process checks every write and per-cycle output invariants.
module tb_imem_loader;

  localparam int AW  = 10;
  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .cpu_hold(cpu_hold), .done(done), .err(err),
    .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int             n_vec = 0;
  int             n_err = 0;
  logic [AW+31:0] exp_q[$];
  logic [7:0]     stream_q[$];
  bit             m_done;
  bit             m_err;
  int             m_words;
  logic [31:0]    last_wdata = '0;
  logic [AW-1:0]  last_addr = '0;
  int             we_count = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected effect of sending stream_q (possibly truncated, then stalled):
  // every complete word up to N is written in order; a bad header or a
  // stream that ends short of N words ends in err.
  function automatic void model();
    int n;
    int avail;
    n = {stream_q[0], stream_q[1]};
    if (n == 0 || n > (1 << AW)) begin
      m_done = 0; m_err = 1; m_words = 0;
      return;
    end
    avail   = (stream_q.size() - 2) / 4;
    m_words = (avail < n) ? avail : n;
    for (int w = 0; w < m_words; w++)
      exp_q.push_back({AW'(w), stream_q[2+4*w], stream_q[3+4*w],
                       stream_q[4+4*w], stream_q[5+4*w]});
    m_done = (avail >= n);
    m_err  = !m_done;
  endfunction

  // Compare process: writes against the expected queue, plus invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      check("hold_eq_busy", cpu_hold, busy);
      check("done_err_excl", done && err, 0);
      check("ready_implies_busy", in_ready && !busy, 0);
      if (mem_we) begin
        we_count++;
        last_wdata = mem_wdata;
        last_addr  = mem_addr;
        check("we_while_busy", busy, 1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: addr %0h data %0h, none required",
                   mem_addr, mem_wdata);
        end else begin
          logic [AW+31:0] e;
          e = exp_q.pop_front();
          check("write_addr", mem_addr, e[AW+31:32]);
          check("write_data", mem_wdata, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    in_data  = b;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      send_byte(stream_q[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: busy stayed 1, required 0");
    end
  endtask

  task automatic check_end(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, m_done);
    check({tag, "_err"}, err, m_err);
    check({tag, "_words"}, words_loaded, m_words);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic set_stream(input int n, input int nbytes, input int seed);
    stream_q.delete();
    stream_q.push_back(8'(n >> 8));
    stream_q.push_back(8'(n));
    for (int i = 0; i < nbytes; i++)
      stream_q.push_back(8'((i * 37 + seed * 11 + 5) ^ (i >> 2)));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int wc;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words", words_loaded, 0);
    check("rst_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1) single word
    stream_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    model();
    pulse_start();
    feed(0, stream_q.size() - 1, 0);
    wait_idle();
    check_end("t1");
    check("t1_wdata_lit", last_wdata, 32'h12345678);
    check("t1_addr_lit", last_addr, 0);
    check("t1_words_lit", words_loaded, 1);

    // 2) three words, in_valid toggling every other cycle
    set_stream(3, 12, 2);
    model();
    pulse_start();
    feed(0, stream_q.size() - 1, 1);
    wait_idle();
    check_end("t2");
    check("t2_last_addr_lit", last_addr, 2);
    check("t2_done_lit", done, 1);

    // 3) zero count, then oversize count 1025
    wc = we_count;
    stream_q = '{8'h00, 8'h00};
    model();
    pulse_start();
    feed(0, 1, 0);
    check("t3a_ready_after_hdr", in_ready, 0);
    check_end("t3a");
    stream_q = '{8'h04, 8'h01};
    model();
    pulse_start();
    check("t3_err_cleared", err, 0);
    feed(0, 1, 0);
    check("t3b_ready_after_hdr", in_ready, 0);
    check_end("t3b");
    check("t3_no_writes", we_count - wc, 0);

    // 4) N=2, stall after 6 data bytes: abort after 15 idle cycles
    wc = we_count;
    set_stream(2, 6, 4);
    model();
    pulse_start();
    feed(0, stream_q.size() - 1, 0);
    repeat (14) @(negedge clk);
    check("t4_err_at_14", err, 0);
    @(negedge clk);
    check("t4_err_at_15", err, 1);
    check_end("t4");
    check("t4_one_write_lit", we_count - wc, 1);
    check("t4_words_lit", words_loaded, 1);

    // 5) reset in the middle of word 5 (index 4)
    set_stream(8, 18, 5);
    model();
    pulse_start();
    feed(0, stream_q.size() - 1, 0);
    check("t5_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_hold", cpu_hold, 0);
    check("t5_rst_ready", in_ready, 0);
    check("t5_rst_we", mem_we, 0);
    check("t5_rst_addr", mem_addr, 0);
    check("t5_rst_wdata", mem_wdata, 0);
    check("t5_rst_words", words_loaded, 0);
    check("t5_rst_err", err, 0);
    check("t5_writes_before_rst", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stream_q = '{8'h00, 8'h01, 8'hde, 8'had, 8'hbe, 8'hef};
    model();
    pulse_start();
    feed(0, stream_q.size() - 1, 0);
    wait_idle();
    check_end("t5");
    check("t5_addr_lit", last_addr, 0);

    // 6) start pulses mid-load and in the final WRITE cycle are ignored
    set_stream(2, 8, 6);
    model();
    pulse_start();
    feed(0, 5, 0);
    pulse_start();
    feed(6, 8, 0);
    send_byte(stream_q[9]);
    check("t6_in_write", mem_we, 1);
    pulse_start();
    check("t6_busy_after_write", busy, 0);
    check("t6_done_kept", done, 1);
    @(negedge clk);
    check_end("t6");
    stream_q = '{8'h00, 8'h01, 8'h0a, 8'h0b, 8'h0c, 8'h0d};
    model();
    pulse_start();
    check("t6_done_cleared", done, 0);
    check("t6_busy_new", busy, 1);
    feed(0, stream_q.size() - 1, 0);
    wait_idle();
    check_end("t6b");
    check("t6b_wdata_lit", last_wdata, 32'h0a0b0c0d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
